// File: rtl/nes_dma_pkg.sv
// Shared definitions for the NES DMA engines (sprite OAM DMA now, DMC later).
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    GET   = 3'd3,
    PUT   = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;

  // Source address of a get cycle: page selects the 256-byte block, idx the byte.
  function automatic logic [15:0] dma_get_addr(input logic [7:0] page, input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/dma_cycle_parity.sv
// Free-running get/put slot parity: 0 = get slot, 1 = put slot; cleared by sync reset.
module dma_cycle_parity (
  input  logic clk_i,
  input  logic rst_i,
  output logic parity_o
);

  logic parity_q;

  // Toggle every CPU cycle; reset starts on a get slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
    end
  end

  assign parity_o = parity_q;

endmodule

// File: rtl/sprite_dma_ctrl.sv
// Sprite OAM DMA: halts the CPU via RDY, then copies page P*256..P*256+255 to OAMDATA.
// Optional feature macro: SPRITE_DMA_ABORT_EN (adds the ABORT input).
module sprite_dma_ctrl
  import nes_dma_pkg::*;
#(
  parameter logic [15:0] REG_ADDR = OAMDMA_ADDR,
  parameter logic [15:0] DST_ADDR = OAMDATA_ADDR
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DOUT,
  input  logic [7:0]  DB_IN,
`ifdef SPRITE_DMA_ABORT_EN
  input  logic        ABORT,
`endif
  output logic        RDY,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RD,
  output logic        DMA_WR,
  output logic [7:0]  DMA_DOUT,
  output logic        DONE
);

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        rdy_q, rdy_d;
  logic        act_q, act_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic [15:0] addr_q, addr_d;
  logic        parity_s;
  logic        abort_s;

`ifdef SPRITE_DMA_ABORT_EN
  assign abort_s = ABORT;
`else
  assign abort_s = 1'b0;
`endif

  dma_cycle_parity u_parity (
    .clk_i    (CLK),
    .rst_i    (RES),
    .parity_o (parity_s)
  );

  // Next-state logic; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (CPU_WR && (CPU_ADDR == REG_ADDR)) begin
          page_d  = CPU_DOUT;
          idx_d   = 8'd0;
          state_d = HALT;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        // The core ignores RDY on writes; the first read is the halt cycle.
        if (abort_s) begin
          state_d = IDLE;
        end else if (!CPU_WR) begin
          state_d = parity_s ? GET : ALIGN;
        end else begin
          state_d = HALT;
        end
      end
      ALIGN: begin
        state_d = abort_s ? IDLE : GET;
      end
      GET: begin
        byte_d  = DB_IN;
        state_d = abort_s ? IDLE : PUT;
      end
      PUT: begin
        if (idx_q == 8'hFF) begin
          state_d = IDLE;
          done_d  = ~abort_s;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = abort_s ? IDLE : GET;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d  = 1'b1;
    act_d  = 1'b0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    addr_d = 16'h0000;
    case (state_d)
      IDLE:  begin rdy_d = 1'b1; end
      HALT:  begin rdy_d = 1'b0; end
      ALIGN: begin rdy_d = 1'b0; act_d = 1'b1; end
      GET: begin
        rdy_d  = 1'b0;
        act_d  = 1'b1;
        rd_d   = 1'b1;
        addr_d = dma_get_addr(page_d, idx_d);
      end
      PUT: begin
        rdy_d  = 1'b0;
        act_d  = 1'b1;
        wr_d   = 1'b1;
        addr_d = DST_ADDR;
      end
      default: begin rdy_d = 1'b1; end
    endcase
  end

  // State, counters, byte latch and registered outputs.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= IDLE;
      page_q  <= 8'd0;
      idx_q   <= 8'd0;
      byte_q  <= 8'd0;
      rdy_q   <= 1'b1;
      act_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      rdy_q   <= rdy_d;
      act_q   <= act_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
    end
  end

  assign RDY        = rdy_q;
  assign DMA_ACTIVE = act_q;
  assign DMA_ADDR   = addr_q;
  assign DMA_RD     = rd_q;
  assign DMA_WR     = wr_q;
  assign DMA_DOUT   = byte_q;
  assign DONE       = done_q;

endmodule
